// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension sequencer and its combinational datapath.
package mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_m.sv
// Purely combinational MUL/DIV/REM datapath; intended to be timed as a multicycle path.
module alu_m
    import mdu_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic [2:0]       op,
    output logic [Width-1:0] c
);

    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

    logic                   a_sgn;
    logic                   b_sgn;
    logic [2*Width-1:0]     a_w;
    logic [2*Width-1:0]     b_w;
    logic [2*Width-1:0]     prod;
    logic                   dz;
    logic                   ovf;
    logic [Width-1:0]       udiv_b;
    logic [Width-1:0]       sdiv_b;

    always_comb begin
        a_sgn  = (op == OP_MULH) || (op == OP_MULHSU);
        b_sgn  = (op == OP_MULH);
        // Modulo-2^(2W) product gives the correct high half for every signedness mix.
        a_w    = {{Width{a_sgn & a[Width-1]}}, a};
        b_w    = {{Width{b_sgn & b[Width-1]}}, b};
        prod   = a_w * b_w;
        dz     = (b == '0);
        ovf    = (a == MinVal) && (b == '1);
        udiv_b = dz ? Width'(1) : b;
        sdiv_b = (dz || ovf) ? Width'(1) : b;
        c      = '0;
        unique case (op)
            OP_MUL:    c = prod[Width-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  c = prod[2*Width-1:Width];
            OP_DIV:    c = $signed(a) / $signed(sdiv_b);
            OP_DIVU:   c = a / udiv_b;
            OP_REM:    c = $signed(a) % $signed(sdiv_b);
            OP_REMU:   c = a % udiv_b;
            default:   c = '0;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle sequencer around alu_m: holds operands for a settle window, applies the
// architectural divide-by-zero / overflow results, and returns them over valid/ready.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int Width     = 32,
    parameter int MulCycles = 2,
    parameter int DivCycles = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [Width-1:0] req_a,
    input  logic [Width-1:0] req_b,
    input  logic [2:0]       req_op,
    input  logic [4:0]       req_rd,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [Width-1:0] rsp_c,
    output logic [4:0]       rsp_rd,
    output logic             busy
);

    localparam int MaxCyc = (MulCycles > DivCycles) ? MulCycles : DivCycles;
    localparam int CntW   = $clog2(MaxCyc) + 1;
    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

    mdu_state_t       state_q, state_d;
    logic [Width-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] rsp_c_q, rsp_c_d;
    logic [4:0]       rsp_rd_q, rsp_rd_d;
    logic [Width-1:0] alu_c;
    logic [Width-1:0] final_c;

    function automatic logic div_special(input logic [2:0] op, input logic [Width-1:0] a,
                                         input logic [Width-1:0] b);
        return is_div(op) && ((b == '0) || (!op[0] && (a == MinVal) && (b == '1)));
    endfunction

    alu_m #(.Width(Width)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .c  (alu_c)
    );

    assign req_ready = (state_q == ST_IDLE) && !flush;
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_c     = rsp_c_q;
    assign rsp_rd    = rsp_rd_q;

    // op[1] separates REM/REMU from DIV/DIVU among the divide ops.
    always_comb begin
        final_c = alu_c;
        if (is_div(op_q) && (b_q == '0)) begin
            final_c = op_q[1] ? a_q : '1;
        end else if (div_special(op_q, a_q, b_q)) begin
            final_c = op_q[1] ? '0 : MinVal;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        rsp_c_d  = rsp_c_q;
        rsp_rd_d = rsp_rd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    rd_d    = req_rd;
                    state_d = ST_EXEC;
                    if (div_special(req_op, req_a, req_b)) begin
                        cnt_d = '0;
                    end else if (is_div(req_op)) begin
                        cnt_d = CntW'(DivCycles - 1);
                    end else begin
                        cnt_d = CntW'(MulCycles - 1);
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_c_d  = final_c;
                    rsp_rd_d = rd_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over completion and consumption; the pending result never lands.
        if (flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            rsp_c_d  = rsp_c_q;
            rsp_rd_d = rsp_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            rsp_c_q  <= '0;
            rsp_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            rsp_c_q  <= rsp_c_d;
            rsp_rd_q <= rsp_rd_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a response scoreboard queue.
module tb_mdu_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic [4:0]  req_rd;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_c;
    logic [4:0]  rsp_rd;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    mdu_seq #(.Width(32), .MulCycles(2), .DivCycles(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_rd    (rsp_rd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [36:0] e;
        chk1({tag, "_valid"}, rsp_valid, 1'b1);
        chk1({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk32({tag, "_c"}, rsp_c, e[31:0]);
            chk32({tag, "_rd"}, 32'(rsp_rd), 32'(e[36:32]));
        end
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
    endtask

    // Returns the number of edges after acceptance until rsp_valid, bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_c, input int exp_n);
        int n;
        chk1({tag, "_req_ready"}, req_ready, 1'b1);
        drive_req(op, a, b, rd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_q.push_back({rd, exp_c});
        wait_rsp(n);
        chk32({tag, "_latency"}, 32'(n), 32'(exp_n));
        pop_check(tag);
        @(posedge clk);
        #1;
        chk1({tag, "_consumed"}, rsp_valid, 1'b0);
    endtask

    initial begin
        int n;
        logic seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_rd    = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        #3;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_rsp_c", rsp_c, 32'h0);
        chk32("rst_rsp_rd", 32'(rsp_rd), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("mul",      3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2);
        do_op("mulh",     3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 2);
        do_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFF, 2);
        do_op("mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 2);
        do_op("div",      3'd4, 32'hFFFFFFEC, 32'd3,        5'd10, 32'hFFFFFFFA, 8);
        do_op("remu",     3'd7, 32'd20,       32'd6,        5'd11, 32'd2,        8);
        do_op("div_z",    3'd4, 32'd55,       32'd0,        5'd12, 32'hFFFFFFFF, 1);
        do_op("divu_z",   3'd5, 32'd55,       32'd0,        5'd13, 32'hFFFFFFFF, 1);
        do_op("rem_z",    3'd6, 32'h1234,     32'd0,        5'd14, 32'h1234,     1);
        do_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
        do_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h0,        1);
        do_op("divu_big", 3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h0,        8);

        // Backpressure: result held in DONE while a new request waits.
        rsp_ready = 1'b0;
        drive_req(3'd4, 32'd100, 32'd7, 5'd9);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_q.push_back({5'd9, 32'd14});
        wait_rsp(n);
        chk32("bp_latency", 32'(n), 32'd8);
        drive_req(3'd0, 32'd3, 32'd4, 5'd2);
        for (int i = 0; i < 5; i++) begin
            chk1("bp_req_ready", req_ready, 1'b0);
            chk1("bp_rsp_valid", rsp_valid, 1'b1);
            chk32("bp_rsp_c", rsp_c, 32'd14);
            chk32("bp_rsp_rd", 32'(rsp_rd), 32'd9);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        pop_check("bp");
        @(posedge clk);
        #1;
        chk1("bp_released_valid", rsp_valid, 1'b0);
        chk1("bp_released_ready", req_ready, 1'b1);
        exp_q.push_back({5'd2, 32'd12});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk1("bp_next_busy", busy, 1'b1);
        wait_rsp(n);
        chk32("bp_next_latency", 32'(n), 32'd2);
        pop_check("bp_next");
        @(posedge clk);
        #1;

        // Flush on the third EXEC cycle of a divide.
        drive_req(3'd4, 32'd50, 32'd5, 5'd3);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk1("fl_exec_busy", busy, 1'b1);
        chk1("fl_exec_req_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk1("fl_exec_idle", busy, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk1("fl_exec_no_rsp", seen, 1'b0);

        // Flush in DONE with rsp_ready high drops the result.
        rsp_ready = 1'b0;
        drive_req(3'd0, 32'd2, 32'd3, 5'd4);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp(n);
        chk32("fl_done_latency", 32'(n), 32'd2);
        rsp_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk1("fl_done_valid", rsp_valid, 1'b0);
        chk1("fl_done_busy", busy, 1'b0);

        // Flush blocks a simultaneous request in IDLE.
        flush = 1'b1;
        drive_req(3'd0, 32'd5, 32'd5, 5'd1);
        #1;
        chk1("fl_idle_req_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        chk1("fl_idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        chk1("fl_idle_still_idle", busy, 1'b0);

        do_op("post_flush", 3'd0, 32'd9, 32'd9, 5'd20, 32'd81, 2);

        // Asynchronous reset in the middle of EXEC.
        drive_req(3'd4, 32'd99, 32'd9, 5'd7);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("rst_exec_valid", rsp_valid, 1'b0);
        chk1("rst_exec_busy", busy, 1'b0);
        chk32("rst_exec_c", rsp_c, 32'h0);
        chk32("rst_exec_rd", 32'(rsp_rd), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid || busy) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk1("rst_exec_no_rsp", seen, 1'b0);

        do_op("post_rst", 3'd5, 32'hFFFFFFFF, 32'd0, 5'd31, 32'hFFFFFFFF, 1);
        chk1("sb_drained", exp_q.size() == 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
